// File: rtl/sfe_pkg.sv
// Shared definitions for the serial frame extractor: FSM state encoding and
// default header/length parameters.
package sfe_pkg;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StLen    = 2'd1,
    StData   = 2'd2
  } sfe_state_e;

  localparam int unsigned SfePatW    = 4;
  localparam logic [3:0]  SfePattern = 4'b1101;
  localparam int unsigned SfeLenW    = 4;

endpackage

// File: rtl/frame_counter.sv
// Payload down-counter: loads the frame length and counts delivered bits down,
// saturating at zero.
module frame_counter #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic [LEN_W-1:0] cnt,
  output logic             is_one
);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clk_en) begin
      if (load) begin
        cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
        cnt_d = cnt_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign is_one = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/serial_frame_extractor.sv
// Serial frame extractor: hunts for a header pattern, reads a length field,
// then forwards that many payload bits with a per-bit valid strobe.
module serial_frame_extractor
  import sfe_pkg::*;
#(
  parameter int unsigned      PAT_W   = SfePatW,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SfePattern),
  parameter int unsigned      LEN_W   = SfeLenW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic [LEN_W-1:0] cnt_out,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned HistW   = PAT_W - 1;
  localparam int unsigned BitCntW = (LEN_W > 1) ? $clog2(LEN_W) : 1;

  sfe_state_e         state_q, state_d;
  logic [HistW-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   len_shift;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               hdr_hit;
  logic               cnt_load;
  logic               cnt_dec;
  logic [LEN_W-1:0]   cnt;
  logic               cnt_is_one;

  assign hdr_hit   = ({hist_q, ser_in} == PATTERN);
  assign len_shift = (len_q << 1) | LEN_W'(ser_in);

  always_comb begin
    state_d       = state_q;
    hist_d        = hist_q;
    len_d         = len_q;
    bit_cnt_d     = bit_cnt_q;
    frame_done_d  = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    ser_out_valid = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        StSearch: begin
          if (hdr_hit) begin
            state_d   = StLen;
            bit_cnt_d = '0;
            // History stays frozen outside SEARCH, so clearing here empties it on return.
            hist_d    = '0;
          end else begin
            hist_d = (hist_q << 1) | HistW'(ser_in);
          end
        end
        StLen: begin
          len_d = len_shift;
          if (bit_cnt_q == BitCntW'(LEN_W - 1)) begin
            bit_cnt_d = '0;
            if (len_shift == '0) begin
              state_d      = StSearch;
              frame_done_d = 1'b1;
            end else begin
              state_d  = StData;
              cnt_load = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
        StData: begin
          ser_out_valid = 1'b1;
          cnt_dec       = 1'b1;
          if (cnt_is_one) begin
            state_d      = StSearch;
            frame_done_d = 1'b1;
          end
        end
        default: begin
          state_d = StSearch;
          hist_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StSearch;
      hist_q       <= '0;
      len_q        <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      len_q        <= len_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  frame_counter #(
    .LEN_W(LEN_W)
  ) u_frame_counter (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .load    (cnt_load),
    .load_val(len_shift),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .is_one  (cnt_is_one)
  );

  assign ser_out    = ser_in;
  assign cnt_out    = (state_q == StData) ? cnt : '0;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == StLen) || (state_q == StData);

endmodule

// File: tb/tb_serial_frame_extractor.sv
// Self-checking bench: queue-based frame model compared every cycle, plus
// directed frames with literal expectations and a randomized soak.
module tb_serial_frame_extractor;

  localparam int         PW  = 4;
  localparam logic [3:0] PAT = 4'b1101;
  localparam int         LW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          ser_in;
  logic          ser_out;
  logic          ser_out_valid;
  logic [LW-1:0] cnt_out;
  logic          frame_done;
  logic          busy;

  always #5 clk = ~clk;

  serial_frame_extractor #(
    .PAT_W  (PW),
    .PATTERN(PAT),
    .LEN_W  (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .ser_in       (ser_in),
    .ser_out      (ser_out),
    .ser_out_valid(ser_out_valid),
    .cnt_out      (cnt_out),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  // Model: 0 = hunting header, 1 = collecting length, 2 = delivering payload
  int m_phase;
  bit win[$];
  int lcount;
  int lval;
  int rem;
  bit m_done;

  int checks = 0;
  int errors = 0;
  bit got[$];
  int cnt_log[$];
  int fd_seen;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    win.delete();
    lcount = 0;
    lval   = 0;
    rem    = 0;
    m_done = 1'b0;
  endtask

  function automatic int win_value();
    int v = 0;
    foreach (win[i]) v = v * 2 + int'(win[i]);
    return v;
  endfunction

  function automatic int got_value();
    int v = 0;
    foreach (got[i]) v = v * 2 + int'(got[i]);
    return v;
  endfunction

  task automatic clear_log();
    got.delete();
    cnt_log.delete();
    fd_seen = 0;
  endtask

  // One clock: drive, compare against model at negedge, then advance the model.
  task automatic cycle(input bit r, input bit en, input bit b);
    rst    = r;
    clk_en = en;
    ser_in = b;
    @(negedge clk);
    check("ser_out", int'(ser_out), int'(b));
    check("ser_out_valid", int'(ser_out_valid), int'(!r && m_phase == 2 && en));
    check("cnt_out", int'(cnt_out), (!r && m_phase == 2) ? rem : 0);
    check("busy", int'(busy), int'(!r && m_phase != 0));
    check("frame_done", int'(frame_done), int'(!r && m_done));
    if (ser_out_valid) begin
      got.push_back(ser_out);
      cnt_log.push_back(int'(cnt_out));
    end
    if (frame_done) fd_seen++;
    if (r) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      if (en) begin
        if (m_phase == 0) begin
          win.push_back(b);
          if (win.size() > PW) void'(win.pop_front());
          if (win.size() == PW && win_value() == int'(PAT)) begin
            m_phase = 1;
            lcount  = 0;
            lval    = 0;
            win.delete();
          end
        end else if (m_phase == 1) begin
          lval = lval * 2 + int'(b);
          lcount++;
          if (lcount == LW) begin
            if (lval == 0) begin
              m_phase = 0;
              m_done  = 1'b1;
            end else begin
              m_phase = 2;
              rem     = lval;
            end
          end
        end else begin
          rem--;
          if (rem == 0) begin
            m_phase = 0;
            m_done  = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b1, v[i]);
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b0;
    ser_in = 1'b0;
    model_reset();
    clear_log();

    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check("reset_cnt_out", int'(cnt_out), 0);
    check("reset_busy", int'(busy), 0);

    // Basic 3-bit frame
    clear_log();
    send(32'b1101_0011_101, 11);
    send(32'b0, 3);
    check("t1_nbits", got.size(), 3);
    check("t1_payload", got_value(), 3'b101);
    check("t1_cnt0", cnt_log.size() > 0 ? cnt_log[0] : -1, 3);
    check("t1_cnt1", cnt_log.size() > 1 ? cnt_log[1] : -1, 2);
    check("t1_cnt2", cnt_log.size() > 2 ? cnt_log[2] : -1, 1);
    check("t1_done", fd_seen, 1);

    // Zero-length frame
    clear_log();
    send(32'b1101_0000, 8);
    send(32'b0, 2);
    check("t2_nbits", got.size(), 0);
    check("t2_done", fd_seen, 1);
    check("t2_busy", int'(busy), 0);

    // Overlapping header
    clear_log();
    send(32'b11101_0001_1, 10);
    send(32'b0, 3);
    check("t3_nbits", got.size(), 1);
    check("t3_payload", got_value(), 1);
    check("t3_done", fd_seen, 1);

    // clk_en toggling through the payload
    clear_log();
    send(32'b1101_0010, 8);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check("t4_hold", int'(cnt_out), 1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    send(32'b0, 3);
    check("t4_nbits", got.size(), 2);
    check("t4_payload", got_value(), 2'b10);
    check("t4_cnt0", cnt_log.size() > 0 ? cnt_log[0] : -1, 2);
    check("t4_cnt1", cnt_log.size() > 1 ? cnt_log[1] : -1, 1);
    check("t4_done", fd_seen, 1);

    // Header inside payload ignored, following header found
    clear_log();
    send(32'b1101_0110_110101, 14);
    send(32'b1101_0001_0, 9);
    send(32'b0, 3);
    check("t5_nbits", got.size(), 7);
    check("t5_payload", got_value(), 7'b1101010);
    check("t5_done", fd_seen, 2);

    // Reset mid-payload
    clear_log();
    send(32'b1101_0111_11, 10);
    check("t6_cnt_before", int'(cnt_out), 5);
    check("t6_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("t6_cnt_rst", int'(cnt_out), 0);
    check("t6_busy_rst", int'(busy), 0);
    cycle(1'b1, 1'b1, 1'b0);
    send(32'b0, 3);
    check("t6_no_done", fd_seen, 0);
    clear_log();
    send(32'b1101_0011_101, 11);
    send(32'b0, 3);
    check("t6_nbits", got.size(), 3);
    check("t6_payload", got_value(), 3'b101);
    check("t6_done", fd_seen, 1);

    // Randomized soak
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
